alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
// - Parametrised, registered successor to the datapath ALU, with a valid/ready handshake on input and output.
// - Shifts are multi-cycle (one bit per cycle) and an optional multiplier is multi-cycle.
// - Flags are registered per result, plus a sticky copy.
// - Sits between the register file (operands A=R0, B=RX) and the writeback/flag register of the core.
// PARAMETERS
// - W      8  operand/result width (>=4)
// - SHW    $clog2(W)+1  internal shift-counter width (derived, not overridden)
// PORTS
// - CLK        in   1   clock; all logic on rising edge
// - RST_N      in   1   reset, synchronous, active-low
// - IN_VALID   in   1   operands/opcode valid
// - IN_READY   out  1   block can accept (high only in IDLE)
// - OP         in   4   opcode, see BEHAVIOUR
// - A_DATO     in   W   operand A (R0)
// - B_DATO     in   W   operand B (RX); shift amount for SHL/SHR
// - OUT_VALID  out  1   RESUL/FLAGS valid
// - OUT_READY  in   1   consumer accepts result
// - RESUL      out  W   result
// - FLAGS      out  4   {Z,C,N,V} of current result
// - STICKY     out  4   OR-accumulated FLAGS since last clear
// - FLAG_CLR   in   1   clears STICKY
// - ERR        out  1   current result came from an illegal opcode
// BEHAVIOUR
// - Reset (RST_N=0 at edge): state IDLE; IN_READY=1; OUT_VALID=0; RESUL=0; FLAGS=0; STICKY=0; ERR=0.
//   - Applies from any state, aborting any in-flight op without producing a result.
// - FSM IDLE -> EXEC -> DONE -> IDLE.
//   - IDLE: accept when IN_VALID&IN_READY; latch A, B, OP.
//     - Single-cycle ops, or a shift with amount 0: go to DONE.
//     - Otherwise go to EXEC.
//   - EXEC: one shift/add step per cycle; counter down to 0, then go to DONE. IN_READY=0.
//   - DONE: OUT_VALID=1; RESUL/FLAGS/ERR stable until OUT_READY=1, then go to IDLE.
//     - No same-cycle re-accept: throughput is at most one op per 2 cycles.
// - Latency (accept edge to OUT_VALID): 1 cycle for logic/arith; 1+amt for shifts; W+1 for MUL.
// - Opcodes:
//   - 0000 ADD A+B (W+1 bit)
//   - 0001 SUB A-B
//   - 0010 SHL A<<B
//   - 0011 SHR A>>B (logical)
//   - 0100 NOT ~B
//   - 0101 AND
//   - 0110 OR
//   - 0111 XOR
//   - 1000 MUL (see CONFIGURATION)
//   - All others illegal: RESUL=0, FLAGS=4'b1000, ERR=1, latency 1.
// - Shift amount: amt = min(B, W). amt>=W yields RESUL=0.
// - Flags:
//   - Z = (RESUL==0).
//   - N = RESUL[W-1].
//   - C:
//     - ADD: carry out.
//     - SUB: borrow (A<B unsigned).
//     - SHL/SHR: last bit shifted out (0 if amt=0).
//     - Logic/NOT: 0.
//   - V:
//     - ADD/SUB: signed two's-complement overflow.
//     - Others: 0.
// - STICKY <= STICKY | FLAGS on each DONE entry.
//   - FLAG_CLR alone: STICKY <= 0.
//   - FLAG_CLR on the same edge as DONE entry: STICKY <= new FLAGS (the clear loses nothing new).
// - IN_VALID while busy is ignored, not queued; the source must hold it until IN_READY.
// - OP/A/B changes after accept have no effect on the in-flight op.
// CONFIGURATION
// - ALU_MUL_EN defined:
//   - OP 1000 = unsigned A*B via shift-add over W EXEC cycles; RESUL = low W bits.
//   - C = V = (high W bits != 0); Z/N from RESUL.
// - ALU_MUL_EN undefined:
//   - OP 1000 is illegal (ERR=1, latency 1).
//   - No multiplier logic is synthesised.
// TESTING
// - Reset mid-op: W=8, SHL A=8'h01 B=5, pull RST_N low in the 3rd EXEC cycle
//   -> next cycle IN_READY=1, OUT_VALID=0, STICKY=0, RESUL=0.
// - ADD 8'hFF+8'h01 -> RESUL=8'h00, FLAGS Z=1 C=1 N=0 V=0, OUT_VALID 1 cycle after accept.
//   ADD 8'h7F+8'h01 -> 8'h80, N=1 V=1 C=0.
// - SUB 8'h03-8'h05 -> RESUL=8'hFE, C=1 N=1 V=0.
//   SHR 8'h81 B=1 -> 8'h40, C=1, OUT_VALID 2 cycles after accept.
//   SHL B=200 -> RESUL=0, Z=1, latency 9.
// - Backpressure: hold OUT_READY=0 for 5 cycles after DONE -> RESUL/FLAGS stable, IN_READY=0, new IN_VALID ignored.
//   FLAG_CLR on the same edge as the next DONE entry -> STICKY equals that op's FLAGS.
// - Illegal op OP=4'b1111 -> RESUL=0, FLAGS=4'b1000, ERR=1.
//   MUL 8'h10*8'h10:
//   - ALU_MUL_EN defined: RESUL=8'h00, Z=1 C=1 V=1, latency 9.
//   - ALU_MUL_EN undefined: ERR=1, latency 1.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake and data bundle between the core and the sequential ALU.
//   Input side : IN_VALID/IN_READY handshake carrying OP, A_DATO, B_DATO.
//   Output side: OUT_VALID/OUT_READY handshake carrying RESUL, FLAGS ({Z,C,N,V}), ERR.
//   Flag state : STICKY (OR-accumulated FLAGS), FLAG_CLR (clears STICKY).
// Modports: master = core side (drives operands, consumes results), slave = ALU side.
interface alu_seq_if #(
  parameter int unsigned W = 8
);
  logic         IN_VALID;
  logic         IN_READY;
  logic [3:0]   OP;
  logic [W-1:0] A_DATO;
  logic [W-1:0] B_DATO;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] RESUL;
  logic [3:0]   FLAGS;
  logic [3:0]   STICKY;
  logic         FLAG_CLR;
  logic         ERR;

  modport master (
    output IN_VALID, OP, A_DATO, B_DATO, OUT_READY, FLAG_CLR,
    input  IN_READY, OUT_VALID, RESUL, FLAGS, STICKY, ERR
  );

  modport slave (
    input  IN_VALID, OP, A_DATO, B_DATO, OUT_READY, FLAG_CLR,
    output IN_READY, OUT_VALID, RESUL, FLAGS, STICKY, ERR
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes. Logic/arith ops finish in one
// cycle; shifts step one bit per cycle; the optional shift-add multiplier takes W cycles.
// Flags {Z,C,N,V} are registered with each result and OR-accumulated into STICKY.
// Ports:
//   CLK   - clock, rising edge
//   RST_N - synchronous active-low reset
//   bus   - alu_seq_if.slave (operand handshake, result handshake, flags, FLAG_CLR, ERR)
// Build option: define ALU_MUL_EN to enable opcode 4'b1000 (MUL); otherwise it is illegal.
module alu_seq #(
  parameter int unsigned W = 8
) (
  input logic      CLK,
  input logic      RST_N,
  alu_seq_if.slave bus
);
  localparam int unsigned SHW = $clog2(W) + 1;
  localparam logic [W-1:0] WLim = W'(W);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpShl = 4'b0010;
  localparam logic [3:0] OpShr = 4'b0011;
  localparam logic [3:0] OpNot = 4'b0100;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpOr  = 4'b0110;
  localparam logic [3:0] OpXor = 4'b0111;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OpMul = 4'b1000;
`endif

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [W-1:0]   work_q, work_d;    // shift working value, multiplicand for MUL
  logic [SHW-1:0] cnt_q, cnt_d;      // EXEC steps still to run
  logic           carry_q, carry_d;  // last bit shifted out
  logic [W-1:0]   res_q, res_d;
  logic [3:0]     flags_q, flags_d;
  logic [3:0]     sticky_q, sticky_d;
  logic           err_q, err_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
`ifdef ALU_MUL_EN
  logic [2*W-1:0] prod_q, prod_d;    // {partial high, remaining multiplier bits}
  logic [W:0]     mul_sum;
`endif

  logic [W:0]     add_w, sub_w;
  logic           add_ovf, sub_ovf;
  logic [SHW-1:0] amt;
  logic           fin;
  logic [W-1:0]   fin_res;
  logic           fin_c, fin_v, fin_err;
  logic [3:0]     fin_flags;

  assign add_w   = {1'b0, bus.A_DATO} + {1'b0, bus.B_DATO};
  assign sub_w   = {1'b0, bus.A_DATO} - {1'b0, bus.B_DATO};
  assign add_ovf = (bus.A_DATO[W-1] == bus.B_DATO[W-1]) && (add_w[W-1] != bus.A_DATO[W-1]);
  assign sub_ovf = (bus.A_DATO[W-1] != bus.B_DATO[W-1]) && (sub_w[W-1] != bus.A_DATO[W-1]);
  // Shift amounts of W or more saturate at W: the result is then all zeros.
  assign amt     = (bus.B_DATO >= WLim) ? SHW'(W) : bus.B_DATO[SHW-1:0];
`ifdef ALU_MUL_EN
  assign mul_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, work_q} : '0);
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    res_d       = res_q;
    flags_d     = flags_q;
    sticky_d    = sticky_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef ALU_MUL_EN
    prod_d      = prod_q;
`endif
    fin         = 1'b0;
    fin_res     = '0;
    fin_c       = 1'b0;
    fin_v       = 1'b0;
    fin_err     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.IN_VALID) begin
          op_d       = bus.OP;
          work_d     = bus.A_DATO;
          carry_d    = 1'b0;
          in_ready_d = 1'b0;
          fin        = 1'b1;
          case (bus.OP)
            OpAdd: begin
              fin_res = add_w[W-1:0];
              fin_c   = add_w[W];
              fin_v   = add_ovf;
            end
            OpSub: begin
              fin_res = sub_w[W-1:0];
              fin_c   = sub_w[W];
              fin_v   = sub_ovf;
            end
            OpShl, OpShr: begin
              if (amt != '0) begin
                fin     = 1'b0;
                cnt_d   = amt;
                state_d = StExec;
              end else begin
                fin_res = bus.A_DATO;
              end
            end
            OpNot: fin_res = ~bus.B_DATO;
            OpAnd: fin_res = bus.A_DATO & bus.B_DATO;
            OpOr:  fin_res = bus.A_DATO | bus.B_DATO;
            OpXor: fin_res = bus.A_DATO ^ bus.B_DATO;
`ifdef ALU_MUL_EN
            OpMul: begin
              fin     = 1'b0;
              cnt_d   = SHW'(W);
              prod_d  = {{W{1'b0}}, bus.B_DATO};
              state_d = StExec;
            end
`endif
            default: fin_err = 1'b1;
          endcase
        end
      end
      StExec: begin
        // One step per cycle; the step that empties the counter also enters DONE.
        cnt_d = cnt_q - SHW'(1);
        case (op_q)
          OpShl: begin
            carry_d = work_q[W-1];
            work_d  = {work_q[W-2:0], 1'b0};
            fin_res = work_d;
            fin_c   = carry_d;
          end
          OpShr: begin
            carry_d = work_q[0];
            work_d  = {1'b0, work_q[W-1:1]};
            fin_res = work_d;
            fin_c   = carry_d;
          end
`ifdef ALU_MUL_EN
          OpMul: begin
            prod_d  = {mul_sum, prod_q[W-1:1]};
            fin_res = prod_d[W-1:0];
            fin_c   = |prod_d[2*W-1:W];
            fin_v   = fin_c;
          end
`endif
          default: ;
        endcase
        fin = (cnt_q == SHW'(1));
      end
      StDone: begin
        if (bus.OUT_READY) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase

    fin_flags = {fin_res == '0, fin_c, fin_res[W-1], fin_v};
    if (fin) begin
      state_d     = StDone;
      out_valid_d = 1'b1;
      res_d       = fin_res;
      flags_d     = fin_flags;
      err_d       = fin_err;
      // A clear coinciding with DONE entry keeps the new flags.
      sticky_d    = (bus.FLAG_CLR ? 4'b0000 : sticky_q) | fin_flags;
    end else if (bus.FLAG_CLR) begin
      sticky_d = 4'b0000;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      op_q        <= 4'b0000;
      work_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      res_q       <= '0;
      flags_q     <= 4'b0000;
      sticky_q    <= 4'b0000;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      prod_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      sticky_q    <= sticky_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
      prod_q      <= prod_d;
`endif
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.RESUL     = res_q;
  assign bus.FLAGS     = flags_q;
  assign bus.STICKY    = sticky_q;
  assign bus.ERR       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (W=8).
module tb_alu_seq;
  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpShl = 4'b0010;
  localparam logic [3:0] OpShr = 4'b0011;
  localparam logic [3:0] OpNot = 4'b0100;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpOr  = 4'b0110;
  localparam logic [3:0] OpXor = 4'b0111;
  localparam logic [3:0] OpMul = 4'b1000;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_fails;
  logic [3:0] sticky_m;

  alu_seq_if #(.W(8)) bus ();

  alu_seq #(.W(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat, input logic [7:0] exp_res,
                        input logic [3:0] exp_fl, input logic exp_err);
    logic clr;
    int   lat;
    check({tag, ".in_ready"}, 32'(bus.IN_READY), 32'd1);
    bus.OP       = op;
    bus.A_DATO   = a;
    bus.B_DATO   = b;
    bus.IN_VALID = 1'b1;
    clr          = bus.FLAG_CLR;
    tick();
    // Scramble the inputs after accept; the in-flight op must not notice.
    bus.IN_VALID = 1'b0;
    bus.FLAG_CLR = 1'b0;
    bus.A_DATO   = ~a;
    bus.B_DATO   = ~b;
    bus.OP       = 4'b0000;
    lat = 1;
    while (!bus.OUT_VALID && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".resul"}, 32'(bus.RESUL), 32'(exp_res));
    check({tag, ".flags"}, 32'(bus.FLAGS), 32'(exp_fl));
    check({tag, ".err"}, 32'(bus.ERR), 32'(exp_err));
    sticky_m = clr ? exp_fl : (sticky_m | exp_fl);
    check({tag, ".sticky"}, 32'(bus.STICKY), 32'(sticky_m));
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    check({tag, ".out_valid_drop"}, 32'(bus.OUT_VALID), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    sticky_m      = 4'b0000;
    RST_N         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.OP        = 4'b0000;
    bus.A_DATO    = 8'h00;
    bus.B_DATO    = 8'h00;
    bus.OUT_READY = 1'b0;
    bus.FLAG_CLR  = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;

    // Reset state
    check("rst.in_ready", 32'(bus.IN_READY), 32'd1);
    check("rst.out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst.resul", 32'(bus.RESUL), 32'd0);
    check("rst.flags", 32'(bus.FLAGS), 32'd0);
    check("rst.sticky", 32'(bus.STICKY), 32'd0);
    check("rst.err", 32'(bus.ERR), 32'd0);

    // Signed overflow: {Z,C,N,V} = 0011
    run_op("add7f", OpAdd, 8'h7F, 8'h01, 1, 8'h80, 4'b0011, 1'b0);

    // Reset in the 3rd EXEC cycle of SHL 1<<5
    bus.OP       = OpShl;
    bus.A_DATO   = 8'h01;
    bus.B_DATO   = 8'd5;
    bus.IN_VALID = 1'b1;
    tick();
    bus.IN_VALID = 1'b0;
    check("midrst.busy", 32'(bus.IN_READY), 32'd0);
    tick();
    tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    sticky_m = 4'b0000;
    check("midrst.in_ready", 32'(bus.IN_READY), 32'd1);
    check("midrst.out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("midrst.sticky", 32'(bus.STICKY), 32'd0);
    check("midrst.resul", 32'(bus.RESUL), 32'd0);
    repeat (6) tick();
    check("midrst.no_result", 32'(bus.OUT_VALID), 32'd0);

    run_op("addff", OpAdd, 8'hFF, 8'h01, 1, 8'h00, 4'b1100, 1'b0);
    run_op("sub", OpSub, 8'h03, 8'h05, 1, 8'hFE, 4'b0110, 1'b0);
    run_op("shr1", OpShr, 8'h81, 8'd1, 2, 8'h40, 4'b0100, 1'b0);
    run_op("shl200", OpShl, 8'hA5, 8'd200, 9, 8'h00, 4'b1100, 1'b0);
    run_op("shl7", OpShl, 8'h03, 8'd7, 8, 8'h80, 4'b0110, 1'b0);
    run_op("shl0", OpShl, 8'h81, 8'd0, 1, 8'h81, 4'b0010, 1'b0);
    run_op("not", OpNot, 8'h00, 8'h0F, 1, 8'hF0, 4'b0010, 1'b0);
    run_op("and", OpAnd, 8'hC3, 8'h0F, 1, 8'h03, 4'b0000, 1'b0);
    run_op("or", OpOr, 8'h00, 8'h00, 1, 8'h00, 4'b1000, 1'b0);
    run_op("xor", OpXor, 8'hAA, 8'h55, 1, 8'hFF, 4'b0010, 1'b0);
    run_op("illegal", 4'b1111, 8'h12, 8'h34, 1, 8'h00, 4'b1000, 1'b1);
`ifdef ALU_MUL_EN
    run_op("mul10", OpMul, 8'h10, 8'h10, 9, 8'h00, 4'b1101, 1'b0);
    run_op("mul53", OpMul, 8'h05, 8'h03, 9, 8'h0F, 4'b0000, 1'b0);
`else
    run_op("mul10", OpMul, 8'h10, 8'h10, 1, 8'h00, 4'b1000, 1'b1);
`endif

    // FLAG_CLR alone
    bus.FLAG_CLR = 1'b1;
    tick();
    bus.FLAG_CLR = 1'b0;
    sticky_m = 4'b0000;
    check("clr.sticky", 32'(bus.STICKY), 32'd0);

    // Backpressure: result held, new requests ignored
    run_op("pre_bp", OpSub, 8'h80, 8'h01, 1, 8'h7F, 4'b0001, 1'b0);
    bus.OP       = OpAdd;
    bus.A_DATO   = 8'h12;
    bus.B_DATO   = 8'h34;
    bus.IN_VALID = 1'b1;
    tick();
    check("bp.valid", 32'(bus.OUT_VALID), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.IN_VALID = 1'b1;
      bus.OP       = OpXor;
      bus.A_DATO   = 8'(i);
      bus.B_DATO   = 8'hFF;
      tick();
      check("bp.resul", 32'(bus.RESUL), 32'h46);
      check("bp.flags", 32'(bus.FLAGS), 32'd0);
      check("bp.in_ready", 32'(bus.IN_READY), 32'd0);
      check("bp.out_valid", 32'(bus.OUT_VALID), 32'd1);
    end
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
    check("bp.release_valid", 32'(bus.OUT_VALID), 32'd0);
    check("bp.release_ready", 32'(bus.IN_READY), 32'd1);
    repeat (3) tick();
    check("bp.not_queued", 32'(bus.OUT_VALID), 32'd0);

    // FLAG_CLR on the DONE-entry edge: STICKY becomes exactly the new flags
    bus.FLAG_CLR = 1'b1;
    run_op("clr_done", OpSub, 8'h03, 8'h05, 1, 8'hFE, 4'b0110, 1'b0);
    check("clr_done.sticky_hold", 32'(bus.STICKY), 32'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
